// File: rtl/chip_top_sys.sv
// Chip top: UART console that sends a boot banner after reset, then echoes
// received bytes through a small RTS/CTS flow-controlled FIFO. SPI port held idle.
module chip_top_sys #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk_p,
  input  logic clk_n,
  input  logic rst_top,
  input  logic rxd,
  output logic txd,
  input  logic cts,
  output logic rts,
  output logic spi_cs,
  output logic spi_sclk,
  output logic spi_mosi,
  input  logic spi_miso
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] N_FULL    = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] N_ALMOST  = NW'(FIFO_DEPTH - 1);

  // Valid/ready: RX offers a byte for one cycle (push); the FIFO takes it only
  // if a slot is free that cycle. TX consumes the head (pop) only when non-empty.

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_BANNER, TX_ECHO, TX_SEND} tx_state_e;

  logic unused_ok;
  assign unused_ok = ^{clk_n, spi_miso};

  assign spi_cs   = 1'b1;
  assign spi_sclk = 1'b0;
  assign spi_mosi = 1'b1;

  // Reset asserts asynchronously and releases two clocks after rst_top rises.
  logic rst_meta_q, rst_n_q;
  always_ff @(posedge clk_p or negedge rst_top) begin
    if (!rst_top) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  logic rxd_meta_q, rxd_sync_q, rxd_prev_q, cts_meta_q, cts_sync_q;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            push, push_ok, pop;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic            rts_q, rts_d;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [8:0]      tx_sh_q, tx_sh_d;
  logic            txd_q, txd_d;
  logic [2:0]      ban_idx_q, ban_idx_d;
  logic [7:0]      ban_byte;
  logic            ban_left, tx_free;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    push       = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          push       = rxd_sync_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A full FIFO still accepts a push in a cycle where TX frees a slot.
  always_comb begin
    push_ok  = push && ((fifo_cnt_q != N_FULL) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + NW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - NW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    rts_d = (fifo_cnt_q >= N_ALMOST);
  end

  always_comb begin
    case (ban_idx_q[1:0])
      2'd0:    ban_byte = 8'h4C;
      2'd1:    ban_byte = 8'h52;
      2'd2:    ban_byte = 8'h0D;
      default: ban_byte = 8'h0A;
    endcase
  end

  // The launch decision is also taken on the last stop-bit cycle so the next
  // start bit follows with no idle gap.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    ban_idx_d  = ban_idx_q;
    pop        = 1'b0;
    ban_left   = !ban_idx_q[2];
    tx_free    = (tx_state_q != TX_SEND) || ((tx_bit_q == 4'd9) && (tx_cnt_q == BIT_LAST));
    if (!tx_free) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 4'd1;
        txd_d    = tx_sh_q[0];
        tx_sh_d  = {1'b1, tx_sh_q[8:1]};
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end else if (!cts_sync_q && (ban_left || (fifo_cnt_q != '0))) begin
      tx_state_d = TX_SEND;
      txd_d      = 1'b0;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      if (ban_left) begin
        tx_sh_d   = {1'b1, ban_byte};
        ban_idx_d = ban_idx_q + 3'd1;
      end else begin
        tx_sh_d = {1'b1, mem_q[rd_ptr_q]};
        pop     = 1'b1;
      end
    end else begin
      tx_state_d = ban_left ? TX_BANNER : TX_ECHO;
      txd_d      = 1'b1;
    end
  end

  always_ff @(posedge clk_p or negedge rst_n_q) begin
    if (!rst_n_q) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      rts_q      <= 1'b1;
      tx_state_q <= TX_BANNER;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '1;
      txd_q      <= 1'b1;
      ban_idx_q  <= '0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      cts_meta_q <= cts;
      cts_sync_q <= cts_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      rts_q      <= rts_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      ban_idx_q  <= ban_idx_d;
    end
  end

  assign txd = txd_q;
  assign rts = rts_q;

endmodule

// File: tb/tb_chip_top_sys.sv
// Bench for chip_top_sys: banner, echo, flow control, framing/glitch rejection
// and reset abort, with a bit-exact txd frame monitor fed from an expected queue.
module tb_chip_top_sys;
  localparam int CPB = 100;

  logic clk = 1'b0;
  logic clk_n_w;
  logic rst_top, rxd, cts, spi_miso;
  logic txd, rts, spi_cs, spi_sclk, spi_mosi;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int starts[$];

  always #5 clk = ~clk;
  assign clk_n_w = ~clk;

  chip_top_sys #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk_p(clk), .clk_n(clk_n_w), .rst_top(rst_top),
    .rxd(rxd), .txd(txd), .cts(cts), .rts(rts),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int val, input int lo, input int hi);
    n_vec++;
    if (val < lo || val > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // txd frame monitor: each frame is compared cycle by cycle against the
  // waveform of the expected byte popped at its start bit.
  logic       mon_busy = 1'b0;
  logic       mon_bad, mon_unexp;
  int         mon_cyc;
  logic [7:0] mon_exp, mon_dec;
  logic [9:0] mon_frame;

  always @(negedge clk) begin
    cyc++;
    if (!rst_top) begin
      mon_busy = 1'b0;
    end else if (!mon_busy && txd === 1'b0) begin
      mon_busy  = 1'b1;
      mon_cyc   = 0;
      mon_bad   = 1'b0;
      mon_dec   = 8'h00;
      mon_unexp = (exp_q.size() == 0);
      starts.push_back(cyc);
      if (mon_unexp) begin
        mon_exp = 8'h00;
        n_vec++;
        n_bad++;
        $display("FAIL tx_unexpected_frame: got start bit at cycle %0d expected idle line", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
      end
      mon_frame = {1'b1, mon_exp, 1'b0};
    end
    if (mon_busy && rst_top) begin
      if (txd !== mon_frame[mon_cyc / CPB]) mon_bad = 1'b1;
      if ((mon_cyc % CPB) == CPB / 2 && (mon_cyc / CPB) >= 1 && (mon_cyc / CPB) <= 8)
        mon_dec[(mon_cyc / CPB) - 1] = txd;
      mon_cyc++;
      if (mon_cyc == 10 * CPB) begin
        mon_busy = 1'b0;
        if (!mon_unexp) check("tx_byte", {23'd0, mon_bad, mon_dec}, {23'd0, 1'b0, mon_exp});
      end
    end
  end

  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check(name, {31'd0, (exp_q.size() == 0 && !mon_busy)}, 32'd1);
  endtask

  task automatic push_banner();
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       echo;
  } echo_vec_t;

  echo_vec_t tbl[6];
  logic      rts_fill[5];

  initial begin
    int n0, t_send, lat, k;

    tbl[0] = '{8'hA5, 1'b1, 1'b1};
    tbl[1] = '{8'h00, 1'b1, 1'b1};
    tbl[2] = '{8'hFF, 1'b1, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 1'b0};
    tbl[4] = '{8'h81, 1'b1, 1'b1};
    tbl[5] = '{8'h7E, 1'b1, 1'b1};
    rts_fill = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_top = 1'b1; rxd = 1'b1; cts = 1'b0; spi_miso = 1'b0;
    #1 rst_top = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_rts", {31'd0, rts}, 32'd1);
    check("rst_spi_cs", {31'd0, spi_cs}, 32'd1);
    check("rst_spi_sclk", {31'd0, spi_sclk}, 32'd0);
    check("rst_spi_mosi", {31'd0, spi_mosi}, 32'd1);

    // Banner after reset release, back to back.
    push_banner();
    starts.delete();
    rst_top = 1'b1;
    @(negedge clk);
    check("rts_held_in_sync", {31'd0, rts}, 32'd1);
    k = 1;
    while (rts !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    check_rng("rts_release_cycles", k, 2, 4);
    wait_drain(6000, "banner_drain");
    check("banner_frames", starts.size(), 32'd4);
    for (int i = 0; i < 3 && i + 1 < starts.size(); i++)
      check("banner_gap", starts[i + 1] - starts[i], 10 * CPB);
    repeat (200) @(negedge clk);
    check("idle_after_banner", {31'd0, txd}, 32'd1);
    check("frames_after_idle", starts.size(), 32'd4);

    // Echo vectors, one frame each, with latency measured from rxd start.
    foreach (tbl[i]) begin
      n0 = starts.size();
      if (tbl[i].echo) exp_q.push_back(tbl[i].data);
      t_send = cyc;
      uart_send(tbl[i].data, tbl[i].stop);
      wait_drain(3000, "echo_drain");
      if (tbl[i].echo) begin
        lat = (starts.size() > n0) ? starts[n0] - t_send : -1;
        check_rng("echo_latency", lat, CPB * 19 / 2, CPB * 19 / 2 + 8);
      end else begin
        check("framing_no_echo", starts.size() - n0, 32'd0);
        check("framing_fifo_cnt", {29'd0, dut.fifo_cnt_q}, 32'd0);
      end
      check("echo_rts", {31'd0, rts}, 32'd0);
      repeat (20) @(negedge clk);
    end

    // Short low glitch must not start a byte.
    n0 = starts.size();
    rxd = 1'b0;
    repeat (30) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_no_echo", starts.size() - n0, 32'd0);
    check("glitch_fifo_cnt", {29'd0, dut.fifo_cnt_q}, 32'd0);
    check("glitch_rts", {31'd0, rts}, 32'd0);

    // Flow control: fill with cts held off; fifth byte overflows and is dropped.
    cts = 1'b1;
    repeat (4) @(negedge clk);
    n0 = starts.size();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'(i + 1));
      uart_send(8'(i + 1), 1'b1);
      check("rts_fill", {31'd0, rts}, {31'd0, rts_fill[i]});
    end
    repeat (100) @(negedge clk);
    check("cts_hold_no_tx", starts.size() - n0, 32'd0);
    check("full_fifo_cnt", {29'd0, dut.fifo_cnt_q}, 32'd4);
    cts = 1'b0;
    wait_drain(6000, "flow_drain");
    check("flow_frames", starts.size() - n0, 32'd4);
    check("flow_rts_after", {31'd0, rts}, 32'd0);

    // cts held off across reset release, then released, then raised mid-byte.
    cts = 1'b1;
    rst_top = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    rst_top = 1'b1;
    n0 = starts.size();
    repeat (200) @(negedge clk);
    check("cts_hold_txd", {31'd0, txd}, 32'd1);
    check("cts_hold_frames", starts.size() - n0, 32'd0);
    push_banner();
    cts = 1'b0;
    k = 0;
    while (txd !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    check_rng("cts_release_latency", k, 1, 3);
    repeat (300) @(negedge clk);
    cts = 1'b1;
    repeat (15 * CPB) @(negedge clk);
    check("cts_midbyte_frames", starts.size() - n0, 32'd1);
    check("cts_midbyte_left", exp_q.size(), 32'd3);
    cts = 1'b0;
    wait_drain(5000, "cts_drain");

    // Reset in the middle of a banner byte aborts it; banner restarts.
    rst_top = 1'b0;
    repeat (5) @(negedge clk);
    starts.delete();
    push_banner();
    rst_top = 1'b1;
    k = 0;
    while (starts.size() < 2 && k < 3000) begin @(negedge clk); k++; end
    check("midbanner_reached", starts.size(), 32'd2);
    repeat (300) @(negedge clk);
    rst_top = 1'b0;
    #1;
    check("rst_async_txd", {31'd0, txd}, 32'd1);
    exp_q.delete();
    repeat (5) @(negedge clk);
    starts.delete();
    push_banner();
    rst_top = 1'b1;
    wait_drain(6000, "rebanner_drain");
    check("rebanner_frames", starts.size(), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chip_top_sys.md
Name: chip_top_sys

Overview:
- Minimal FPGA chip top: brings up a UART console, transmits a fixed boot banner after reset, then echoes every received byte back.
- Received bytes are buffered in a small FIFO with RTS/CTS flow control.
- The SPI (SD-card) port is present, with outputs held idle.
- Sits directly under the board wrapper, fed by the board differential clock and the push-button reset.

Parameters:
- CLKS_PER_BIT, 868, clk_p cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
- FIFO_DEPTH, 4, RX echo FIFO entries (power of two).

Ports:
- clk_p  input  1  system clock, positive leg; all logic is clocked on its rising edge.
- clk_n  input  1  negative leg of the same clock; unused internally.
- rst_top  input  1  asynchronous active-low reset.
- rxd  input  1  UART receive, idle high.
- txd  output  1  UART transmit, idle high.
- cts  input  1  active-low clear-to-send; TX may start a byte only when 0.
- rts  output  1  active-low request-to-send; 0 = chip can accept data.
- spi_cs  output  1  SPI chip select, active low.
- spi_sclk  output  1  SPI clock.
- spi_mosi  output  1  SPI data out.
- spi_miso  input  1  SPI data in; ignored.

Behaviour:
- Reset (rst_top=0, asynchronous):
  - Outputs: txd=1, rts=1, spi_cs=1, spi_sclk=0, spi_mosi=1.
  - State: FIFO empty, TX FSM in BANNER with index 0, RX FSM IDLE, all counters 0.
  - Reset asserted mid-byte aborts the byte immediately; txd returns to 1 asynchronously.
  - Reset release is synchronised internally with a 2-flop synchroniser, so logic leaves reset 2 cycles after rst_top rises.
- rts is registered and equals (fifo_count >= FIFO_DEPTH-1), so 1 means almost full. After reset release it drops to 0 on the first active cycle.
- rxd and cts each pass through a 2-flop synchroniser before use.
- UART frame format: 8N1, LSB first, each bit exactly CLKS_PER_BIT cycles.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a synchronised falling edge of rxd enters START.
  - START: at CLKS_PER_BIT/2 cycles, sample rxd. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: 8 samples, one every CLKS_PER_BIT cycles, mid-bit.
  - STOP: sample once. If 1, push the byte into the FIFO. If 0 (framing error), discard the byte. Return to IDLE immediately after the stop sample.
  - A push when the FIFO is full drops the new byte; the FIFO contents are unchanged.
- TX FSM, states BANNER, ECHO, SEND:
  - Banner is the 4 bytes 0x4C 0x52 0x0D 0x0A ("LR\r\n"), sent once per reset.
  - Byte launch: in BANNER or ECHO, a byte launches when one is available and the synchronised cts is 0. Otherwise the line idles at 1; a deasserted cts holds off the next byte.
  - On launch, go to SEND with the byte latched.
  - SEND drives the start bit 0, then d0..d7, then the stop bit 1.
  - cts changes during SEND do not affect the byte in flight.
  - After SEND, go back to BANNER until all 4 banner bytes have been sent, then go to ECHO.
  - In ECHO, launch pops the FIFO head.
  - Inter-byte gap is 0 cycles: the next start bit follows the stop bit immediately when a byte is ready.
- FIFO:
  - Synchronous, FIFO_DEPTH entries, wrapping pointers, count 0..FIFO_DEPTH.
  - A simultaneous push and pop in the same cycle is legal: count is unchanged. When full, that cycle's push is still accepted because a slot is freed.
  - A pop when empty never occurs; TX checks empty first.
- SPI outputs remain at their reset values at all times.

Test Plan:
- Reset, then rxd=1 and cts=0: banner checked bit-exact on txd. Bytes 0x4C,0x52,0x0D,0x0A back-to-back, each 10*CLKS_PER_BIT cycles. txd stays 1 afterwards.
- After the banner, drive 0xA5 on rxd: 0xA5 echoed on txd, starting within 2 cycles of the RX stop sample (plus synchroniser latency). rts stays 0.
- Hold cts=1 during reset release: txd stays 1. Release cts: banner starts within 3 cycles. Raise cts mid-byte: the current byte completes, then TX stalls.
- cts=1, send 5 bytes 0x01..0x05: rts=1 after the 3rd byte. Byte 5 is dropped. Release cts: echo is 0x01..0x04 only.
- Send a frame with stop bit 0, then a 30-cycle low glitch on rxd: no byte echoed, FIFO count stays 0.
- Assert rst_top mid-banner: txd=1 immediately; after release the full banner restarts from 0x4C.
